serial_lane_sched: RTL and testbench
====================================

# serial_lane_sched

Two-lane symbol scheduler and serializer controller for the PCIe-style physical layer. It generates the per-symbol bit timing from the single bit-rate clock. After every reset it trains both lanes with a burst of COM symbols. It then accepts one byte per lane per symbol slot through a valid/ready strobe, and substitutes IDLE on any lane with no valid data. It sits between the byte-striping logic and the serial output pins and drives out0/out1 directly.

## Interface

Parameters:
- DATA_W, 8: symbol width. Only 8 is supported.
- TRAIN_LEN, 4: number of COM symbols sent per lane after reset. Legal range 1..15.
- COM_SYM, 8'hBC: training symbol.
- IDLE_SYM, 8'h7C: filler symbol for a lane with no valid data.

Ports:
- clk, input, 1: bit clock. One serial bit per rising edge.
- reset, input, 1: synchronous, active-high.
- in0, input, 8: lane 0 byte.
- valid_0, input, 1: in0 holds data.
- in1, input, 8: lane 1 byte.
- valid_1, input, 1: in1 holds data.
- ready_0, output, 1: lane 0 slot strobe. A byte is taken when valid_0 && ready_0.
- ready_1, output, 1: lane 1 slot strobe.
- out0, output, 1: lane 0 serial bit, MSB first.
- out1, output, 1: lane 1 serial bit, MSB first.
- sym_strobe, output, 1: high in the last bit cycle of every symbol.
- link_up, output, 1: high while in ACTIVE.

## Operation

State machine, shared by both lanes (the lanes run in lockstep):
- TRAIN: every symbol boundary loads COM_SYM into both lanes.
  - train_cnt counts 0..TRAIN_LEN-1.
  - The boundary with train_cnt == TRAIN_LEN-1 loads the last COM, clears train_cnt and moves to ACTIVE.
- ACTIVE: every boundary loads each lane independently.
  - Load in_N if valid_N, else IDLE_SYM.
  - Stays in ACTIVE until reset.

Bit timing:
- bit_idx is a 3-bit counter.
- Boundary is the cycle where bit_idx == 7. At the next edge the lane loads its new symbol and bit_idx wraps to 0.
- At every other edge the lane shifts left by one and bit_idx increments.
- out_N = shift_N[7], combinational from the register.

Handshake:
- ready_N = link_up && (bit_idx == 7). This is a pure timing strobe with no backpressure.
- valid_N is sampled only while ready_N is high.
- Upstream holds in_N and valid_N until it sees ready_N.
- A valid byte that is never present in a ready cycle is never sent.
- Each ready cycle consumes at most one byte per lane.

Reset values (applied at the first edge with reset high):
- bit_idx = 7, train_cnt = 0, state = TRAIN.
- shift_0 = shift_1 = 0, so out0 = out1 = 0.
- ready_0 = ready_1 = 0, link_up = 0, sym_strobe = 1 (bit_idx == 7).

Reset mid-operation:
- Any partial symbol is discarded and the outputs drop to 0 at the next edge.
- Training restarts from the first COM after release.

## Timing

- Take edge 1 as the first rising edge with reset low.
- Edge 1 loads COM #1. Edges 1, 9, …, 8·(TRAIN_LEN-1)+1 load COMs.
- link_up rises at the edge loading the last COM, i.e. edge 25 for TRAIN_LEN = 4.
- The first ready cycle is the cycle after edge 8·TRAIN_LEN (edge 32 for TRAIN_LEN = 4). The first data is loaded at edge 8·TRAIN_LEN+1 (edge 33).
- Data latency: the MSB of an accepted byte appears on out_N in the cycle after the accepting edge. The LSB follows 7 cycles later.
- Symbols are continuous, with no gap bits between them.
- Lane 0 and lane 1 boundaries are always coincident.

## Structure

- Package serial_sched_pkg holds:
  - COM_SYM and IDLE_SYM defaults.
  - The state enum {TRAIN, ACTIVE}.
  - BIT_IDX_W = 3.
- Sub-module lane_shifter holds an 8-bit shift register plus the load mux (COM / data / IDLE). It is instantiated once per lane.
- The FSM, bit counter and strobes live in the top module.

## Test plan

1. **Training then idle.** Release reset with valid_0 = valid_1 = 0.
   - out0/out1 carry 10111100 ×4 on edges 1–32, then 01111100 repeating.
   - link_up rises at edge 25.
   - ready first goes high in the cycle after edge 32.
2. **Independent lane fill.** At the first ready, drive in0 = AA with valid_0 = 1, and valid_1 = 0.
   - out0 = 10101010 and out1 = 01111100 on the next 8 bits.
3. **Back-to-back data.** Drive in0 = BC and in1 = EE, both valid, for 5 consecutive ready cycles.
   - 40 contiguous bits per lane with no IDLE inserted.
   - Follow with BB/CC, then CC/BB, in exact order.
4. **Mid-symbol valid.** Raise valid_0 with in0 = 55 when bit_idx = 3 and hold it.
   - The byte is sent only from the next boundary, exactly once.
5. **Reset during ACTIVE at bit_idx = 3.**
   - At the next edge: out0 = out1 = 0, link_up = 0, ready = 0.
   - After release, 4 COMs are sent again before any data.
6. **TRAIN_LEN = 1.**
   - Edge 1 loads COM and link_up rises at that edge.
   - The first data is loaded at edge 9.

Source files
------------

// File: rtl/serial_lane_sched_pkg.sv
// Shared types and defaults for the two-lane symbol scheduler.
package serial_sched_pkg;

    localparam logic [7:0] DEF_COM_SYM  = 8'hBC;
    localparam logic [7:0] DEF_IDLE_SYM = 8'h7C;
    localparam int         BIT_IDX_W    = 3;

    typedef enum logic {
        TRAIN,
        ACTIVE
    } sched_state_t;

    typedef enum logic [1:0] {
        SEL_COM,
        SEL_DATA,
        SEL_IDLE
    } load_sel_t;

    // Training overrides everything; afterwards each lane falls back to IDLE when it has no byte.
    function automatic load_sel_t lane_select(sched_state_t st, logic valid);
        if (st == TRAIN) begin
            return SEL_COM;
        end
        return valid ? SEL_DATA : SEL_IDLE;
    endfunction

endpackage

// File: rtl/serial_lane_sched_if.sv
// Byte-side handshake and serial-side outputs of the two-lane scheduler.
interface serial_lane_sched_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] in0;
    logic [DATA_W-1:0] in1;
    logic              valid_0;
    logic              valid_1;
    logic              ready_0;
    logic              ready_1;
    logic              out0;
    logic              out1;
    logic              sym_strobe;
    logic              link_up;

    modport master (
        output in0, valid_0, in1, valid_1,
        input  ready_0, ready_1, out0, out1, sym_strobe, link_up
    );

    modport slave (
        input  in0, valid_0, in1, valid_1,
        output ready_0, ready_1, out0, out1, sym_strobe, link_up
    );
endinterface

// File: rtl/serial_lane_sched_lane_shifter.sv
// One serial lane: symbol load mux feeding an MSB-first shift register.
module lane_shifter
    import serial_sched_pkg::*;
#(
    parameter int                DATA_W   = 8,
    parameter logic [DATA_W-1:0] COM_SYM  = DEF_COM_SYM,
    parameter logic [DATA_W-1:0] IDLE_SYM = DEF_IDLE_SYM
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  load_sel_t         sel,
    input  logic [DATA_W-1:0] data,
    output logic              msb
);
    logic [DATA_W-1:0] shift_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            shift_reg <= '0;
        end else if (load) begin
            case (sel)
                SEL_COM:  shift_reg <= COM_SYM;
                SEL_DATA: shift_reg <= data;
                default:  shift_reg <= IDLE_SYM;
            endcase
        end else begin
            shift_reg <= {shift_reg[DATA_W-2:0], 1'b0};
        end
    end

    assign msb = shift_reg[DATA_W-1];

endmodule

// File: rtl/serial_lane_sched.sv
// Two-lane scheduler: COM training burst after reset, then one byte per lane
// per 8-bit slot with IDLE fill; both lanes share one bit counter and FSM.
module serial_lane_sched
    import serial_sched_pkg::*;
#(
    parameter int                DATA_W    = 8,
    parameter int                TRAIN_LEN = 4,
    parameter logic [DATA_W-1:0] COM_SYM   = DEF_COM_SYM,
    parameter logic [DATA_W-1:0] IDLE_SYM  = DEF_IDLE_SYM
) (
    input logic                clk,
    input logic                reset,
    serial_lane_sched_if.slave bus
);
    localparam logic [3:0] TRAIN_LAST = 4'(TRAIN_LEN - 1);

    sched_state_t         state;
    logic [BIT_IDX_W-1:0] bit_idx;
    logic [3:0]           train_cnt;
    logic                 link_up_q;
    logic                 ready_q;
    logic                 strobe_q;
    logic                 boundary;
    logic                 out0_bit;
    logic                 out1_bit;
    load_sel_t            sel_0;
    load_sel_t            sel_1;

    assign boundary = (bit_idx == '1);
    assign sel_0    = lane_select(state, bus.valid_0);
    assign sel_1    = lane_select(state, bus.valid_1);

    // Strobes are registered one cycle early (bit_idx == 6) so they line up with bit_idx == 7.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= TRAIN;
            bit_idx   <= '1;
            train_cnt <= '0;
            link_up_q <= 1'b0;
            ready_q   <= 1'b0;
            strobe_q  <= 1'b1;
        end else begin
            bit_idx  <= bit_idx + BIT_IDX_W'(1);
            strobe_q <= (bit_idx == BIT_IDX_W'(6));
            ready_q  <= link_up_q && (bit_idx == BIT_IDX_W'(6));
            if (boundary && state == TRAIN) begin
                if (train_cnt == TRAIN_LAST) begin
                    state     <= ACTIVE;
                    link_up_q <= 1'b1;
                    train_cnt <= '0;
                end else begin
                    train_cnt <= train_cnt + 4'd1;
                end
            end
        end
    end

    lane_shifter #(
        .DATA_W   (DATA_W),
        .COM_SYM  (COM_SYM),
        .IDLE_SYM (IDLE_SYM)
    ) u_lane0 (
        .clk   (clk),
        .reset (reset),
        .load  (boundary),
        .sel   (sel_0),
        .data  (bus.in0),
        .msb   (out0_bit)
    );

    lane_shifter #(
        .DATA_W   (DATA_W),
        .COM_SYM  (COM_SYM),
        .IDLE_SYM (IDLE_SYM)
    ) u_lane1 (
        .clk   (clk),
        .reset (reset),
        .load  (boundary),
        .sel   (sel_1),
        .data  (bus.in1),
        .msb   (out1_bit)
    );

    assign bus.out0       = out0_bit;
    assign bus.out1       = out1_bit;
    assign bus.ready_0    = ready_q;
    assign bus.ready_1    = ready_q;
    assign bus.sym_strobe = strobe_q;
    assign bus.link_up    = link_up_q;

endmodule

// File: tb/tb_serial_lane_sched.sv
// Bench for serial_lane_sched: TRAIN_LEN 4 and 1 instances share stimulus and are
// compared each cycle against an edge-count model of the symbol schedule.
module tb_serial_lane_sched;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] in0, in1;
    logic       valid_0, valid_1;

    int checks = 0;
    int fails  = 0;

    serial_lane_sched_if if4 ();
    serial_lane_sched_if if1 ();

    assign if4.in0 = in0;
    assign if4.in1 = in1;
    assign if4.valid_0 = valid_0;
    assign if4.valid_1 = valid_1;
    assign if1.in0 = in0;
    assign if1.in1 = in1;
    assign if1.valid_0 = valid_0;
    assign if1.valid_1 = valid_1;

    serial_lane_sched #(.TRAIN_LEN(4)) dut4 (.clk(clk), .reset(reset), .bus(if4));
    serial_lane_sched #(.TRAIN_LEN(1)) dut1 (.clk(clk), .reset(reset), .bus(if1));

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Model: edges since reset release decide slot number and bit position.
    int         tl[2] = '{4, 1};
    int         m_n[2];
    logic [7:0] m_sym0[2];
    logic [7:0] m_sym1[2];
    bit         m_known = 1'b0;

    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (reset) begin
                m_n[d] = 0;
            end else begin
                m_n[d] = m_n[d] + 1;
                if ((m_n[d] - 1) % 8 == 0) begin
                    if ((m_n[d] - 1) / 8 < tl[d]) begin
                        m_sym0[d] = 8'hBC;
                        m_sym1[d] = 8'hBC;
                    end else begin
                        m_sym0[d] = valid_0 ? in0 : 8'h7C;
                        m_sym1[d] = valid_1 ? in1 : 8'h7C;
                    end
                end
            end
        end
        if (reset) m_known = 1'b1;
    end

    function automatic logic [5:0] expectOut(int d);
        int   b;
        logic l, s;
        if (m_n[d] == 0) return 6'b000010;
        b = (m_n[d] - 1) % 8;
        l = (m_n[d] >= 8 * (tl[d] - 1) + 1);
        s = (b == 7);
        return {m_sym0[d][7-b], m_sym1[d][7-b], l && s, l && s, s, l};
    endfunction

    always @(negedge clk) begin
        if (m_known) begin
            checkOutput("tl4.outputs", {if4.out0, if4.out1, if4.ready_0, if4.ready_1, if4.sym_strobe, if4.link_up}, expectOut(0));
            checkOutput("tl1.outputs", {if1.out0, if1.out1, if1.ready_0, if1.ready_1, if1.sym_strobe, if1.link_up}, expectOut(1));
        end
    end

    task automatic waitReady();
        int guard = 0;
        while (if4.ready_0 !== 1'b1 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        checkOutput("ready.wait", if4.ready_0, 1'b1);
    endtask

    task automatic shiftIn(output logic [7:0] got0, output logic [7:0] got1);
        got0 = '0;
        got1 = '0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (i == 0) begin
                valid_0 = 1'b0;
                valid_1 = 1'b0;
            end
            got0 = {got0[6:0], if4.out0};
            got1 = {got1[6:0], if4.out1};
        end
    endtask

    task automatic applyStimulus(input logic v0, input logic [7:0] d0, input logic v1, input logic [7:0] d1,
                                 input logic [7:0] exp0, input logic [7:0] exp1, input string name);
        logic [7:0] got0, got1;
        waitReady();
        valid_0 = v0;
        in0     = d0;
        valid_1 = v1;
        in1     = d1;
        shiftIn(got0, got1);
        checkOutput({name, ".lane0"}, got0, exp0);
        checkOutput({name, ".lane1"}, got1, exp1);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [31:0] cap0, cap1;
        logic [39:0] r0, r1, r10;
        logic [7:0]  g0, g1;
        bit          took;

        reset = 1'b1;
        valid_0 = 1'b0;
        valid_1 = 1'b0;
        in0 = '0;
        in1 = '0;
        @(negedge clk);
        checkOutput("reset.tl4", {if4.out0, if4.out1, if4.ready_0, if4.ready_1, if4.sym_strobe, if4.link_up}, 6'b000010);
        @(negedge clk);
        reset = 1'b0;

        // Training then idle
        cap0 = '0;
        cap1 = '0;
        for (int n = 1; n <= 32; n++) begin
            @(negedge clk);
            cap0 = {cap0[30:0], if4.out0};
            cap1 = {cap1[30:0], if4.out1};
            if (n == 1)  checkOutput("tl1.link_edge1", if1.link_up, 1'b1);
            if (n == 7)  checkOutput("tl1.ready_edge7", if1.ready_0, 1'b0);
            if (n == 8)  checkOutput("tl1.ready_edge8", if1.ready_0, 1'b1);
            if (n == 24) checkOutput("tl4.link_edge24", if4.link_up, 1'b0);
            if (n == 25) checkOutput("tl4.link_edge25", if4.link_up, 1'b1);
            if (n == 31) checkOutput("tl4.ready_edge31", if4.ready_0, 1'b0);
            if (n == 32) checkOutput("tl4.ready_edge32", if4.ready_0, 1'b1);
        end
        checkOutput("train.lane0", cap0, {4{8'hBC}});
        checkOutput("train.lane1", cap1, {4{8'hBC}});

        // Independent lane fill, then back-to-back data
        applyStimulus(1'b1, 8'hAA, 1'b0, 8'h00, 8'hAA, 8'h7C, "fill");
        for (int k = 0; k < 5; k++) begin
            applyStimulus(1'b1, 8'hBC, 1'b1, 8'hEE, 8'hBC, 8'hEE, "b2b");
        end
        applyStimulus(1'b1, 8'hBB, 1'b1, 8'hCC, 8'hBB, 8'hCC, "b2b.bbcc");
        applyStimulus(1'b1, 8'hCC, 1'b1, 8'hBB, 8'hCC, 8'hBB, "b2b.ccbb");

        // Mid-symbol valid raised at bit_idx 3, sent once from the next boundary
        repeat (4) @(negedge clk);
        valid_0 = 1'b1;
        in0     = 8'h55;
        waitReady();
        shiftIn(g0, g1);
        checkOutput("mid.lane0", g0, 8'h55);
        checkOutput("mid.lane1", g1, 8'h7C);
        shiftIn(g0, g1);
        checkOutput("mid.once", g0, 8'h7C);

        // Reset while ACTIVE at bit_idx 3
        repeat (4) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checkOutput("midreset.tl4", {if4.out0, if4.out1, if4.ready_0, if4.link_up}, 4'b0000);
        reset   = 1'b0;
        valid_0 = 1'b1;
        in0     = 8'hAA;
        r0 = '0;
        r1 = '0;
        r10 = '0;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (n == 33) valid_0 = 1'b0;
            r0  = {r0[38:0], if4.out0};
            r1  = {r1[38:0], if4.out1};
            r10 = {r10[38:0], if1.out0};
        end
        checkOutput("retrain.lane0", r0, {8'hBC, 8'hBC, 8'hBC, 8'hBC, 8'hAA});
        checkOutput("retrain.lane1", r1, {8'hBC, 8'hBC, 8'hBC, 8'hBC, 8'h7C});
        checkOutput("tl1.first_data", r10, {8'hBC, 8'hAA, 8'hAA, 8'hAA, 8'hAA});

        // Randomized traffic with occasional resets
        took = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            if (took) begin
                valid_0 = ($urandom_range(0, 3) != 0);
                valid_1 = ($urandom_range(0, 3) != 0);
                in0     = 8'($urandom);
                in1     = 8'($urandom);
            end
            if (reset) reset = 1'b0;
            else if ($urandom_range(0, 599) == 0) reset = 1'b1;
            took = (if4.ready_0 === 1'b1);
            @(negedge clk);
        end
        reset = 1'b0;
        repeat (4) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
